intrapred_stream: RTL and testbench

Parametrised, streaming successor to the fixed 4x4/8x8 intra-prediction datapath. It computes V, H and DC prediction for one NxN block from latched neighbour pixels, and accepts the original block one row per beat over a valid/ready handshake. It accumulates per-mode SAD, selects the best available mode, then streams out full-precision signed residual rows under backpressure. It sits between the reconstructed-neighbour fetch and the transform stage, and serves luma and both chroma planes by instantiation.

---
 rtl/intrapred_pkg.sv | 34 +++
 rtl/intrapred_dc_calc.sv | 65 ++++++
 rtl/intrapred_stream.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_intrapred_stream.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intrapred_pkg.sv
// -----------------------------------------------------------------------------
// intrapred_pkg
// Shared types and width helpers for the streaming intra-prediction block.
//   intrapred_mode_e  : prediction mode encoding (V=0, H=1, DC=2)
//   intrapred_state_e : control FSM states
//   sad_w()/res_w()   : widths of the SAD accumulators and signed residuals
// -----------------------------------------------------------------------------
package intrapred_pkg;

  typedef enum logic [1:0] {
    MODE_V  = 2'd0,
    MODE_H  = 2'd1,
    MODE_DC = 2'd2
  } intrapred_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DCCALC = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DECIDE = 3'd3,
    ST_EMIT   = 3'd4
  } intrapred_state_e;

  // An NxN block of PIX_W-bit absolute differences needs 2*log2(N) extra bits.
  function automatic int sad_w(input int blk_n, input int pix_w);
    return pix_w + 2 * $clog2(blk_n);
  endfunction

  // orig - pred spans -(2^PIX_W - 1) .. +(2^PIX_W - 1): one sign bit extra.
  function automatic int res_w(input int pix_w);
    return pix_w + 1;
  endfunction

endpackage

// File: rtl/intrapred_dc_calc.sv
// -----------------------------------------------------------------------------
// intrapred_dc_calc
// Combinational DC predictor: sums the neighbour rows and applies the rounding
// rule selected by neighbour availability. The parent registers dc_val.
// Ports:
//   top_pix, left_pix     : BLK_N packed neighbours, element i at [i*PIX_W +: PIX_W]
//   top_avail, left_avail : neighbour availability
//   dc_val                : DC prediction value
// -----------------------------------------------------------------------------
module intrapred_dc_calc
  import intrapred_pkg::*;
#(
  parameter int BLK_N = 8,
  parameter int PIX_W = 8
) (
  input  logic [BLK_N*PIX_W-1:0] top_pix,
  input  logic [BLK_N*PIX_W-1:0] left_pix,
  input  logic                   top_avail,
  input  logic                   left_avail,
  output logic [PIX_W-1:0]       dc_val
);

  localparam int LOG_N = $clog2(BLK_N);
  // Holds 2*BLK_N pixels plus the rounding term.
  localparam int SUM_W = PIX_W + LOG_N + 1;

  logic [SUM_W-1:0] sum_t_s;
  logic [SUM_W-1:0] sum_l_s;
  logic [SUM_W-1:0] tot_s;

  // Sum of each neighbour row.
  always_comb begin
    sum_t_s = '0;
    sum_l_s = '0;
    for (int i = 0; i < BLK_N; i++) begin
      sum_t_s = sum_t_s + SUM_W'(top_pix[i*PIX_W +: PIX_W]);
      sum_l_s = sum_l_s + SUM_W'(left_pix[i*PIX_W +: PIX_W]);
    end
  end

  // Rounded mean of the available neighbours, mid-grey when none are usable.
  always_comb begin
    tot_s  = '0;
    dc_val = '0;
    case ({top_avail, left_avail})
      2'b11: begin
        tot_s  = (sum_t_s + sum_l_s + SUM_W'(BLK_N)) >> (LOG_N + 1);
        dc_val = tot_s[PIX_W-1:0];
      end
      2'b10: begin
        tot_s  = (sum_t_s + SUM_W'(BLK_N / 2)) >> LOG_N;
        dc_val = tot_s[PIX_W-1:0];
      end
      2'b01: begin
        tot_s  = (sum_l_s + SUM_W'(BLK_N / 2)) >> LOG_N;
        dc_val = tot_s[PIX_W-1:0];
      end
      default: begin
        tot_s  = '0;
        dc_val = PIX_W'(1) << (PIX_W - 1);
      end
    endcase
  end

endmodule

// File: rtl/intrapred_stream.sv
// -----------------------------------------------------------------------------
// intrapred_stream
// Streaming V/H/DC intra prediction for one BLK_N x BLK_N block: latches the
// neighbours on start, accepts the original block one row per beat, picks the
// lowest-SAD available mode, then streams signed residual rows.
// Optional feature macro: INTRAPRED_FORCE_MODE_EN adds force_en/force_mode.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   start                          : begin a block (honoured only when idle)
//   top_pix/left_pix/*_avail       : neighbours and availability, latched on start
//   row_valid/row_ready/row_data   : original rows in, top row first
//   res_valid/res_ready/res_data   : residual rows out, res_last on final row
//   mode, best_sad                 : decision, held until the next block decides
//   busy, done                     : activity flag, end-of-block pulse
// -----------------------------------------------------------------------------
module intrapred_stream
  import intrapred_pkg::*;
#(
  parameter int BLK_N = 8,
  parameter int PIX_W = 8
) (
  input  logic                               clk,
  input  logic                               reset,
`ifdef INTRAPRED_FORCE_MODE_EN
  input  logic                               force_en,
  input  logic [1:0]                         force_mode,
`endif
  input  logic                               start,
  input  logic [BLK_N*PIX_W-1:0]             top_pix,
  input  logic [BLK_N*PIX_W-1:0]             left_pix,
  input  logic                               top_avail,
  input  logic                               left_avail,
  input  logic                               row_valid,
  output logic                               row_ready,
  input  logic [BLK_N*PIX_W-1:0]             row_data,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [BLK_N*res_w(PIX_W)-1:0]      res_data,
  output logic                               res_last,
  output logic [1:0]                         mode,
  output logic [sad_w(BLK_N, PIX_W)-1:0]     best_sad,
  output logic                               busy,
  output logic                               done
);

  localparam int SAD_W  = sad_w(BLK_N, PIX_W);
  localparam int RES_W  = res_w(PIX_W);
  localparam int CNT_W  = $clog2(BLK_N);
  localparam int ROW_W  = BLK_N * PIX_W;
  localparam int RROW_W = BLK_N * RES_W;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(BLK_N - 1);

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    if (a >= b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

  intrapred_state_e  state_q, state_d;
  logic [ROW_W-1:0]  top_q, top_d, left_q, left_d;
  logic              top_av_q, top_av_d, left_av_q, left_av_d;
`ifdef INTRAPRED_FORCE_MODE_EN
  logic              force_en_q, force_en_d;
  logic [1:0]        force_mode_q, force_mode_d;
`endif
  logic [PIX_W-1:0]  dc_q, dc_d, dc_s;
  logic [ROW_W-1:0]  buf_q [BLK_N];
  logic [ROW_W-1:0]  buf_d [BLK_N];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SAD_W-1:0]  sad_v_q, sad_v_d, sad_h_q, sad_h_d, sad_dc_q, sad_dc_d;
  intrapred_mode_e   mode_q, mode_d, sel_mode_s, res_mode_s;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d, sel_sad_s;
  logic              row_ready_q, row_ready_d;
  logic              res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic [RROW_W-1:0] res_data_q, res_data_d, res_row_s;
  logic              busy_q, busy_d, done_q, done_d;
  logic [SAD_W-1:0]  row_sad_v_s, row_sad_h_s, row_sad_dc_s;
  logic [CNT_W-1:0]  res_idx_s;
  logic [ROW_W-1:0]  pred_row_s;

  intrapred_dc_calc #(
    .BLK_N (BLK_N),
    .PIX_W (PIX_W)
  ) u_dc_calc (
    .top_pix    (top_q),
    .left_pix   (left_q),
    .top_avail  (top_av_q),
    .left_avail (left_av_q),
    .dc_val     (dc_s)
  );

  // SAD contribution of the incoming row against each predictor.
  always_comb begin
    row_sad_v_s  = '0;
    row_sad_h_s  = '0;
    row_sad_dc_s = '0;
    for (int c = 0; c < BLK_N; c++) begin
      row_sad_v_s  = row_sad_v_s + SAD_W'(abs_diff(row_data[c*PIX_W +: PIX_W],
                                                   top_q[c*PIX_W +: PIX_W]));
      row_sad_h_s  = row_sad_h_s + SAD_W'(abs_diff(row_data[c*PIX_W +: PIX_W],
                                                   left_q[cnt_q*PIX_W +: PIX_W]));
      row_sad_dc_s = row_sad_dc_s + SAD_W'(abs_diff(row_data[c*PIX_W +: PIX_W], dc_q));
    end
  end

  // Mode choice: visiting DC, H, V with <= lets the lower encoding win ties.
  always_comb begin
    sel_mode_s = MODE_DC;
    sel_sad_s  = sad_dc_q;
    if (left_av_q && (sad_h_q <= sel_sad_s)) begin
      sel_mode_s = MODE_H;
      sel_sad_s  = sad_h_q;
    end else begin
      sel_mode_s = sel_mode_s;
    end
    if (top_av_q && (sad_v_q <= sel_sad_s)) begin
      sel_mode_s = MODE_V;
      sel_sad_s  = sad_v_q;
    end else begin
      sel_mode_s = sel_mode_s;
    end
`ifdef INTRAPRED_FORCE_MODE_EN
    // A forced mode only overrides when its neighbours exist.
    if (force_en_q) begin
      case (force_mode_q)
        2'd0: begin
          if (top_av_q) begin
            sel_mode_s = MODE_V;
            sel_sad_s  = sad_v_q;
          end else begin
            sel_mode_s = sel_mode_s;
          end
        end
        2'd1: begin
          if (left_av_q) begin
            sel_mode_s = MODE_H;
            sel_sad_s  = sad_h_q;
          end else begin
            sel_mode_s = sel_mode_s;
          end
        end
        2'd2: begin
          sel_mode_s = MODE_DC;
          sel_sad_s  = sad_dc_q;
        end
        default: begin
          sel_mode_s = sel_mode_s;
        end
      endcase
    end else begin
      sel_mode_s = sel_mode_s;
    end
`endif
  end

  // Residual of the row to present next: row 0 when deciding, else the following row.
  always_comb begin
    res_idx_s  = (state_q == ST_DECIDE) ? CNT_W'(0) : cnt_q + CNT_W'(1);
    res_mode_s = (state_q == ST_DECIDE) ? sel_mode_s : mode_q;
    pred_row_s = '0;
    res_row_s  = '0;
    for (int c = 0; c < BLK_N; c++) begin
      case (res_mode_s)
        MODE_V:  pred_row_s[c*PIX_W +: PIX_W] = top_q[c*PIX_W +: PIX_W];
        MODE_H:  pred_row_s[c*PIX_W +: PIX_W] = left_q[res_idx_s*PIX_W +: PIX_W];
        default: pred_row_s[c*PIX_W +: PIX_W] = dc_q;
      endcase
      res_row_s[c*RES_W +: RES_W] = {1'b0, buf_q[res_idx_s][c*PIX_W +: PIX_W]}
                                  - {1'b0, pred_row_s[c*PIX_W +: PIX_W]};
    end
  end

  // Control FSM next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    top_d        = top_q;
    left_d       = left_q;
    top_av_d     = top_av_q;
    left_av_d    = left_av_q;
`ifdef INTRAPRED_FORCE_MODE_EN
    force_en_d   = force_en_q;
    force_mode_d = force_mode_q;
`endif
    dc_d         = dc_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    sad_v_d      = sad_v_q;
    sad_h_d      = sad_h_q;
    sad_dc_d     = sad_dc_q;
    mode_d       = mode_q;
    best_sad_d   = best_sad_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_last_d   = res_last_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          top_d        = top_pix;
          left_d       = left_pix;
          top_av_d     = top_avail;
          left_av_d    = left_avail;
`ifdef INTRAPRED_FORCE_MODE_EN
          force_en_d   = force_en;
          force_mode_d = force_mode;
`endif
          state_d      = ST_DCCALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DCCALC: begin
        dc_d     = dc_s;
        sad_v_d  = '0;
        sad_h_d  = '0;
        sad_dc_d = '0;
        cnt_d    = '0;
        state_d  = ST_LOAD;
      end
      ST_LOAD: begin
        if (row_valid && row_ready_q) begin
          buf_d[cnt_q] = row_data;
          sad_v_d      = sad_v_q + row_sad_v_s;
          sad_h_d      = sad_h_q + row_sad_h_s;
          sad_dc_d     = sad_dc_q + row_sad_dc_s;
          if (cnt_q == LAST_ROW) begin
            cnt_d   = '0;
            state_d = ST_DECIDE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DECIDE: begin
        mode_d      = sel_mode_s;
        best_sad_d  = sel_sad_s;
        res_valid_d = 1'b1;
        res_data_d  = res_row_s;
        res_last_d  = 1'b0;
        state_d     = ST_EMIT;
      end
      ST_EMIT: begin
        if (res_valid_q && res_ready) begin
          if (res_last_q) begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            res_data_d  = '0;
            cnt_d       = '0;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            res_data_d = res_row_s;
            res_last_d = ((cnt_q + CNT_W'(1)) == LAST_ROW);
          end
        end else begin
          res_valid_d = res_valid_q;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        res_last_d  = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    row_ready_d = (state_d == ST_LOAD);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      top_q        <= '0;
      left_q       <= '0;
      top_av_q     <= 1'b0;
      left_av_q    <= 1'b0;
`ifdef INTRAPRED_FORCE_MODE_EN
      force_en_q   <= 1'b0;
      force_mode_q <= 2'd0;
`endif
      dc_q         <= '0;
      for (int r = 0; r < BLK_N; r++) begin
        buf_q[r] <= '0;
      end
      cnt_q        <= '0;
      sad_v_q      <= '0;
      sad_h_q      <= '0;
      sad_dc_q     <= '0;
      mode_q       <= MODE_V;
      best_sad_q   <= '0;
      row_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      top_q        <= top_d;
      left_q       <= left_d;
      top_av_q     <= top_av_d;
      left_av_q    <= left_av_d;
`ifdef INTRAPRED_FORCE_MODE_EN
      force_en_q   <= force_en_d;
      force_mode_q <= force_mode_d;
`endif
      dc_q         <= dc_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      sad_v_q      <= sad_v_d;
      sad_h_q      <= sad_h_d;
      sad_dc_q     <= sad_dc_d;
      mode_q       <= mode_d;
      best_sad_q   <= best_sad_d;
      row_ready_q  <= row_ready_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_last_q   <= res_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign row_ready = row_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_last  = res_last_q;
  assign mode      = mode_q;
  assign best_sad  = best_sad_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_intrapred_stream.sv
// -----------------------------------------------------------------------------
// tb_intrapred_stream
// Scoreboard bench for intrapred_stream (BLK_N=4, PIX_W=8). A task-level model
// predicts mode, SAD and residual rows for each block and queues them; an
// independent monitor pops and compares on every residual handshake.
// -----------------------------------------------------------------------------
module tb_intrapred_stream;
  import intrapred_pkg::*;

  localparam int N  = 4;
  localparam int PW = 8;
  localparam int RW = PW + 1;
  localparam int SW = PW + 2 * $clog2(N);

  logic            clk = 1'b0;
  logic            reset, start, top_avail, left_avail, row_valid, res_ready;
  logic [N*PW-1:0] top_pix, left_pix, row_data;
  logic            row_ready, res_valid, res_last, busy, done;
  logic [N*RW-1:0] res_data;
  logic [1:0]      mode;
  logic [SW-1:0]   best_sad;
`ifdef INTRAPRED_FORCE_MODE_EN
  logic            force_en;
  logic [1:0]      force_mode;
`endif

  always #5 clk = ~clk;

  intrapred_stream #(.BLK_N(N), .PIX_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef INTRAPRED_FORCE_MODE_EN
    .force_en   (force_en),
    .force_mode (force_mode),
`endif
    .start      (start),
    .top_pix    (top_pix),
    .left_pix   (left_pix),
    .top_avail  (top_avail),
    .left_avail (left_avail),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_last   (res_last),
    .mode       (mode),
    .best_sad   (best_sad),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [N*RW-1:0] data;
    logic            last;
    logic [1:0]      mode;
    logic [SW-1:0]   sad;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   stall_left = 0;
  bit   rr_rand = 1'b0;

  // Stimulus for the current block.
  int m_top[N], m_left[N], m_blk[N][N];
  bit m_tav, m_lav, m_fen;
  int m_fmode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  function automatic logic [N*PW-1:0] pack_arr(input int a[N]);
    logic [N*PW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = PW'(a[i]);
    return v;
  endfunction

  function automatic int pred(input int m, input int r, input int c, input int dc);
    if (m == 0) return m_top[c];
    if (m == 1) return m_left[r];
    return dc;
  endfunction

  // Reference model: predictions from the neighbour averages, SAD per mode,
  // cheapest available mode (lowest index on ties), then residual rows.
  task automatic model_push();
    int sumt, suml, dc, best, d;
    int sad[3];
    bit av[3];
    exp_t e;
    sumt = 0;
    suml = 0;
    for (int i = 0; i < N; i++) begin
      sumt += m_top[i];
      suml += m_left[i];
    end
    if (m_tav && m_lav) dc = (sumt + suml + N) / (2 * N);
    else if (m_tav)     dc = (sumt + N / 2) / N;
    else if (m_lav)     dc = (suml + N / 2) / N;
    else                dc = 1 << (PW - 1);
    av[0] = m_tav;
    av[1] = m_lav;
    av[2] = 1'b1;
    for (int m = 0; m < 3; m++) begin
      sad[m] = 0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          d = m_blk[r][c] - pred(m, r, c, dc);
          sad[m] += (d < 0) ? -d : d;
        end
    end
    best = -1;
    for (int m = 0; m < 3; m++)
      if (av[m] && (best < 0 || sad[m] < sad[best])) best = m;
    if (m_fen && m_fmode < 3 && av[m_fmode]) best = m_fmode;
    for (int r = 0; r < N; r++) begin
      e.data = '0;
      for (int c = 0; c < N; c++) begin
        d = m_blk[r][c] - pred(best, r, c, dc);
        e.data[c*RW +: RW] = d[RW-1:0];
      end
      e.last = (r == N - 1);
      e.mode = best[1:0];
      e.sad  = sad[best][SW-1:0];
      sb_q.push_back(e);
    end
  endtask

  // res_ready driver: optional random backpressure plus requested stalls.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else begin
        res_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: scoreboard compare on each handshake, hold-under-stall and done checks.
  initial begin : monitor
    exp_t            e;
    bit              prev_stall, done_due;
    logic [N*RW-1:0] prev_data;
    logic            prev_last;
    prev_stall = 1'b0;
    done_due   = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        done_due   = 1'b0;
      end else begin
        chk("done_pulse", done, done_due);
        done_due = 1'b0;
        if (prev_stall) begin
          chk("stall_valid", res_valid, 1'b1);
          chk("stall_data", res_data, prev_data);
          chk("stall_last", res_last, prev_last);
        end
        if (res_valid) begin
          chk("busy_emit", busy, 1'b1);
          if (res_ready) begin
            if (sb_q.size() == 0) begin
              n_checks++;
              $display("FAIL sb_extra_row: actual=%0h required=none", res_data);
            end else begin
              e = sb_q.pop_front();
              chk("res_data", res_data, e.data);
              chk("res_last", res_last, e.last);
              chk("mode", mode, e.mode);
              chk("best_sad", best_sad, e.sad);
              done_due = e.last;
            end
          end
          prev_stall = !res_ready;
          prev_data  = res_data;
          prev_last  = res_last;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  // Present one original row and wait (bounded) for its handshake.
  task automatic send_row(input logic [N*PW-1:0] d);
    bit acc;
    int budget;
    repeat ($urandom_range(0, 2)) begin
      row_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    row_valid = 1'b1;
    row_data  = d;
    budget    = 0;
    acc       = 1'b0;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = row_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) fail_timeout("row_handshake");
    row_valid = 1'b0;
  endtask

  task automatic issue_start();
    start      = 1'b1;
    top_pix    = pack_arr(m_top);
    left_pix   = pack_arr(m_left);
    top_avail  = m_tav;
    left_avail = m_lav;
`ifdef INTRAPRED_FORCE_MODE_EN
    force_en   = m_fen;
    force_mode = m_fmode[1:0];
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run one block from start to done. exp_mode/exp_sad < 0 skip the constant checks.
  task automatic run_block(input bit bp, input int exp_mode, input int exp_sad,
                           input bit chk_row0, input logic [N*RW-1:0] row0);
    int b;
    model_push();
    issue_start();
    for (int r = 0; r < N; r++) send_row(pack_arr(m_blk[r]));
    @(negedge clk);
    chk("lat_t1_valid", res_valid, 1'b0);
    @(negedge clk);
    chk("lat_t2_valid", res_valid, 1'b1);
    if (exp_mode >= 0) chk("dir_mode", mode, exp_mode[1:0]);
    if (exp_sad >= 0)  chk("dir_sad", best_sad, exp_sad[SW-1:0]);
    if (chk_row0)      chk("dir_row0", res_data, row0);
    if (bp) begin
      stall_left = 5;
      @(posedge clk);
      #1;
      start   = 1'b1;
      top_pix = ~top_pix;
      @(posedge clk);
      #1;
      start = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
    b = 0;
    while ((sb_q.size() != 0 || busy) && b < 300) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (b >= 300) fail_timeout("block_done");
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("sb_drained", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int tv, input int lv, input int bv, input bit tav, input bit lav);
    for (int i = 0; i < N; i++) begin
      m_top[i]  = tv;
      m_left[i] = lv;
      for (int c = 0; c < N; c++) m_blk[i][c] = bv;
    end
    m_tav = tav;
    m_lav = lav;
  endtask

  task automatic fill_random(input int style);
    int lim;
    lim = (style == 3) ? 3 : 255;
    for (int i = 0; i < N; i++) begin
      m_top[i]  = $urandom_range(0, lim);
      m_left[i] = $urandom_range(0, lim);
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (style == 1)      m_blk[r][c] = (m_left[r] + $urandom_range(0, 6)) % 256;
        else if (style == 2) m_blk[r][c] = (m_top[c] + $urandom_range(0, 6)) % 256;
        else                 m_blk[r][c] = $urandom_range(0, lim);
      end
    m_tav = $urandom_range(0, 1);
    m_lav = $urandom_range(0, 1);
  endtask

  // Hard stop if anything wedges beyond every bounded wait.
  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N*RW-1:0] zero_row, neg255_row;
    zero_row   = '0;
    neg255_row = {N{9'h101}};
    reset = 1'b1;  start = 1'b0;  row_valid = 1'b0;
    top_pix = '0;  left_pix = '0;  row_data = '0;
    top_avail = 1'b0;  left_avail = 1'b0;
    m_fen = 1'b0;  m_fmode = 0;
`ifdef INTRAPRED_FORCE_MODE_EN
    force_en = 1'b0;  force_mode = 2'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_row_ready", row_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, '0);
    chk("rst_mode", mode, 2'd0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Case 1: flat block equal to top -> V, SAD 0, zero residuals.
    fill(100, 50, 100, 1'b1, 1'b1);
    run_block(1'b0, 0, 0, 1'b1, zero_row);
    // Case 2: rows copy left neighbours -> H.
    fill(200, 0, 0, 1'b1, 1'b1);
    for (int r = 0; r < N; r++) begin
      m_left[r] = 10 * (r + 1);
      for (int c = 0; c < N; c++) m_blk[r][c] = m_left[r];
    end
    run_block(1'b0, 1, 0, 1'b0, zero_row);
    // Case 4: top-only tie between V and DC, residuals all -255.
    fill(255, 0, 0, 1'b1, 1'b0);
    run_block(1'b0, 0, 4080, 1'b1, neg255_row);
    // Case 5: backpressure stall plus ignored start during EMIT.
    fill_random(0);
    run_block(1'b1, -1, -1, 1'b0, zero_row);
    // Case 3: no neighbours -> DC=128.
    fill(0, 0, 128, 1'b0, 1'b0);
    run_block(1'b0, 2, 0, 1'b1, zero_row);
    fill(0, 0, 0, 1'b0, 1'b0);
    run_block(1'b0, 2, 2048, 1'b0, zero_row);

    // Case 6: reset with two rows accepted, then a fresh block.
    fill_random(0);
    issue_start();
    send_row(pack_arr(m_blk[0]));
    send_row(pack_arr(m_blk[1]));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_row_ready", row_ready, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_res_data", res_data, '0);
    chk("mid_rst_res_last", res_last, 1'b0);
    chk("mid_rst_mode", mode, 2'd0);
    chk("mid_rst_sad", best_sad, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    fill(60, 60, 61, 1'b0, 1'b1);
    run_block(1'b0, 1, 16, 1'b0, zero_row);

`ifdef INTRAPRED_FORCE_MODE_EN
    fill(100, 50, 100, 1'b1, 1'b1);
    m_fen = 1'b1;
    m_fmode = 2;
    run_block(1'b0, 2, 400, 1'b0, zero_row);
    m_fen = 1'b0;
    m_fmode = 0;
`endif

    // Randomised blocks under random backpressure.
    rr_rand = 1'b1;
    for (int k = 0; k < 30; k++) begin
      fill_random($urandom_range(0, 3));
      run_block(1'b0, -1, -1, 1'b0, zero_row);
    end
    rr_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
